// File: rtl/i2c_globals_pkg.sv
// Shared I2C widths, enums and bit-ordering helpers for the I2C target register file.
package i2c_globals_pkg;

    localparam int SLAVE_ADDRESS_WIDTH    = 7;
    localparam int REGISTER_ADDRESS_WIDTH = 8;
    localparam int DATA_WIDTH             = 8;
    localparam int SLAVE_MEMORY_SIZE      = 12;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } read_write_e;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } shift_direction_e;

    localparam shift_direction_e SHIFT_DIRECTION = MSB_FIRST;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_target_state_e;

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] r,
                                                      input logic b);
        if (SHIFT_DIRECTION == MSB_FIRST) return {r[DATA_WIDTH-2:0], b};
        else                              return {b, r[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] r);
        if (SHIFT_DIRECTION == MSB_FIRST) return {r[DATA_WIDTH-2:0], 1'b0};
        else                              return {1'b0, r[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic tx_bit(input logic [DATA_WIDTH-1:0] r);
        if (SHIFT_DIRECTION == MSB_FIRST) return r[DATA_WIDTH-1];
        else                              return r[0];
    endfunction

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// Synchronizes raw SCL/SDA into pclk and flags START, STOP and SCL edges.
module i2c_bus_cond_detect (
    input  logic pclk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda
);

    logic scl_meta_q, scl_meta_d;
    logic scl_sync_q, scl_sync_d;
    logic scl_hist_q, scl_hist_d;
    logic sda_meta_q, sda_meta_d;
    logic sda_sync_q, sda_sync_d;
    logic sda_hist_q, sda_hist_d;

    always_comb begin
        scl_meta_d = scl_i;
        scl_sync_d = scl_meta_q;
        scl_hist_d = scl_sync_q;
        sda_meta_d = sda_i;
        sda_sync_d = sda_meta_q;
        sda_hist_d = sda_sync_q;
    end

    // Reset to an idle (released, high) bus so no spurious edge follows reset.
    always_ff @(posedge pclk) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_meta_d;
            scl_sync_q <= scl_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_meta_q <= sda_meta_d;
            sda_sync_q <= sda_sync_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign start    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    assign stop     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
    assign scl_rise = scl_sync_q & ~scl_hist_q;
    assign scl_fall = ~scl_sync_q & scl_hist_q;
    assign sda      = sda_sync_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing MEM_DEPTH byte registers with an auto-incrementing, wrapping pointer.
module i2c_target_regfile
    import i2c_globals_pkg::*;
#(
    parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE_ADDRESS = 7'h68,
    parameter int                             MEM_DEPTH     = SLAVE_MEMORY_SIZE
) (
    input  logic                              pclk,
    input  logic                              reset,
    input  logic                              scl_i,
    input  logic                              sda_i,
    output logic                              sda_oe,
    output logic                              busy,
    output logic                              wr_valid,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]             wr_data
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [REGISTER_ADDRESS_WIDTH-1:0] PTR_LAST = REGISTER_ADDRESS_WIDTH'(MEM_DEPTH - 1);

    logic start, stop, scl_rise, scl_fall, sda_s;

    i2c_bus_cond_detect u_detect (
        .pclk     (pclk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda      (sda_s)
    );

    i2c_target_state_e                  state_q, state_d;
    logic [3:0]                         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]              shreg_q, shreg_d;
    logic [REGISTER_ADDRESS_WIDTH-1:0]  ptr_q, ptr_d;
    read_write_e                        rw_q, rw_d;
    logic                               sda_oe_q, sda_oe_d;
    logic                               busy_q, busy_d;
    logic                               wr_valid_q, wr_valid_d;
    logic [REGISTER_ADDRESS_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]              wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]              mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]              mem_d [MEM_DEPTH];

    function automatic logic [REGISTER_ADDRESS_WIDTH-1:0] ptr_next(
        input logic [REGISTER_ADDRESS_WIDTH-1:0] p);
        if (p == PTR_LAST) return '0;
        else               return p + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_d      = mem_q;

        // Bus conditions win over any SCL-edge action seen in the same cycle.
        if (start) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR, REG, WDATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shreg_d = shift_in(shreg_q, sda_s);
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (state_q == ADDR) begin
                            if (shreg_q[DATA_WIDTH-1:1] == SLAVE_ADDRESS) begin
                                state_d  = ADDR_ACK;
                                rw_d     = read_write_e'(shreg_q[0]);
                                busy_d   = 1'b1;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d  = IDLE;
                            end
                        end else if (state_q == REG) begin
                            if (shreg_q <= PTR_LAST) begin
                                ptr_d    = shreg_q;
                                state_d  = REG_ACK;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d  = IDLE;
                                sda_oe_d = 1'b0;
                            end
                        end else begin
                            mem_d[ptr_q[IDX_W-1:0]] = shreg_q;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = shreg_q;
                            ptr_d      = ptr_next(ptr_q);
                            state_d    = WDATA_ACK;
                            sda_oe_d   = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q == READ) begin
                            state_d  = RDATA;
                            shreg_d  = mem_q[ptr_q[IDX_W-1:0]];
                            sda_oe_d = ~tx_bit(mem_q[ptr_q[IDX_W-1:0]]);
                        end else begin
                            state_d  = REG;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d  = WDATA;
                        cnt_d    = '0;
                        sda_oe_d = 1'b0;
                    end
                end
                RDATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_next(ptr_q);
                            state_d  = RDATA_ACK;
                        end else begin
                            shreg_d  = shift_out(shreg_q);
                            sda_oe_d = ~tx_bit(shift_out(shreg_q));
                        end
                    end
                end
                RDATA_ACK: begin
                    // shreg[0] holds the master's ACK bit between its rise and fall.
                    if (scl_rise) begin
                        shreg_d[0] = sda_s;
                    end else if (scl_fall) begin
                        if (!shreg_q[0]) begin
                            state_d  = RDATA;
                            cnt_d    = '0;
                            shreg_d  = mem_q[ptr_q[IDX_W-1:0]];
                            sda_oe_d = ~tx_bit(mem_q[ptr_q[IDX_W-1:0]]);
                        end else begin
                            state_d  = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d == IDLE) begin
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= WRITE;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            mem_q      <= mem_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: bit-banged I2C master against i2c_target_regfile with hand-computed expectations.
module tb_i2c_target_regfile;

    localparam int Q = 8;

    logic       pclk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic       busy;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_log[$];
    logic        oe_seen;
    logic        busy_seen;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regfile #(
        .SLAVE_ADDRESS (7'h68),
        .MEM_DEPTH     (12)
    ) dut (
        .pclk     (pclk),
        .reset    (reset),
        .scl_i    (scl_m),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (wr_valid) wr_log.push_back({wr_addr, wr_data});
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(b);
        acked = (b == 1'b0);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) read_bit(v[i]);
        write_bit(~master_ack);
    endtask

    task automatic bus_idle();
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic test_reset();
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(2);
        checks++; if (sda_oe !== 1'b0)   begin errors++; $display("FAIL reset_sda_oe got %b exp 0", sda_oe); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b exp 0", wr_valid); end
        checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h exp 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h exp 00", wr_data); end
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        logic [15:0] e0, e1;
        wr_log.delete();
        bus_start();
        write_byte(8'hD0, a0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_after_addr got %b exp 1", busy); end
        write_byte(8'h03, a1);
        write_byte(8'hA5, a2);
        write_byte(8'h5A, a3);
        bus_stop();
        tick(Q);
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL write_addr_ack got %b exp 1", a0); end
        checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL write_reg_ack got %b exp 1", a1); end
        checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL write_data0_ack got %b exp 1", a2); end
        checks++; if (a3 !== 1'b1) begin errors++; $display("FAIL write_data1_ack got %b exp 1", a3); end
        checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL write_count got %0d exp 2", wr_log.size()); end
        e0 = (wr_log.size() > 0) ? wr_log[0] : 16'hxxxx;
        e1 = (wr_log.size() > 1) ? wr_log[1] : 16'hxxxx;
        checks++; if (e0 !== 16'h03A5) begin errors++; $display("FAIL write_pulse0 got %h exp 03A5", e0); end
        checks++; if (e1 !== 16'h045A) begin errors++; $display("FAIL write_pulse1 got %h exp 045A", e1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got %b exp 0", busy); end
    endtask

    task automatic test_read();
        logic a, a0, a1, a2;
        logic [7:0] d0, d1, d2;
        logic [15:0] e0;
        wr_log.delete();
        bus_start();
        write_byte(8'hD0, a);
        write_byte(8'h02, a);
        write_byte(8'h3C, a);
        bus_stop();
        e0 = (wr_log.size() > 0) ? wr_log[0] : 16'hxxxx;
        checks++; if (e0 !== 16'h023C) begin errors++; $display("FAIL read_preload got %h exp 023C", e0); end
        bus_start();
        write_byte(8'hD0, a0);
        write_byte(8'h02, a1);
        bus_start();
        write_byte(8'hD1, a2);
        read_byte(1'b1, d0);
        read_byte(1'b1, d1);
        read_byte(1'b0, d2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_nack got %b exp 0", busy); end
        bus_stop();
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL read_addr_ack got %b exp 1", a0); end
        checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL read_reg_ack got %b exp 1", a1); end
        checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL read_raddr_ack got %b exp 1", a2); end
        checks++; if (d0 !== 8'h3C) begin errors++; $display("FAIL read_byte0 got %h exp 3C", d0); end
        checks++; if (d1 !== 8'hA5) begin errors++; $display("FAIL read_byte1 got %h exp A5", d1); end
        checks++; if (d2 !== 8'h5A) begin errors++; $display("FAIL read_byte2 got %h exp 5A", d2); end
    endtask

    task automatic test_bad_addr();
        logic a;
        wr_log.delete();
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        bus_start();
        write_byte(8'hD2, a);
        write_byte(8'h01, a);
        bus_stop();
        checks++; if (oe_seen !== 1'b0)   begin errors++; $display("FAIL badaddr_sda_oe got %b exp 0", oe_seen); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL badaddr_busy got %b exp 0", busy_seen); end
        checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL badaddr_writes got %0d exp 0", wr_log.size()); end
    endtask

    task automatic test_bad_reg();
        logic a0, a1, a2;
        wr_log.delete();
        bus_start();
        write_byte(8'hD0, a0);
        write_byte(8'h0C, a1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badreg_busy got %b exp 0", busy); end
        write_byte(8'h77, a2);
        bus_stop();
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL badreg_addr_ack got %b exp 1", a0); end
        checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL badreg_reg_nack got %b exp 0", a1); end
        checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL badreg_data_nack got %b exp 0", a2); end
        checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL badreg_writes got %0d exp 0", wr_log.size()); end
    endtask

    task automatic test_wrap();
        logic a;
        logic [15:0] e0, e1;
        wr_log.delete();
        bus_start();
        write_byte(8'hD0, a);
        write_byte(8'h0B, a);
        write_byte(8'h11, a);
        write_byte(8'h22, a);
        bus_stop();
        checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", wr_log.size()); end
        e0 = (wr_log.size() > 0) ? wr_log[0] : 16'hxxxx;
        e1 = (wr_log.size() > 1) ? wr_log[1] : 16'hxxxx;
        checks++; if (e0 !== 16'h0B11) begin errors++; $display("FAIL wrap_pulse0 got %h exp 0B11", e0); end
        checks++; if (e1 !== 16'h0022) begin errors++; $display("FAIL wrap_pulse1 got %h exp 0022", e1); end
    endtask

    task automatic test_partial_stop();
        logic a;
        wr_log.delete();
        bus_start();
        write_byte(8'hD0, a);
        write_byte(8'h01, a);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        bus_stop();
        tick(Q);
        checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL partial_writes got %0d exp 0", wr_log.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic a;
        logic [7:0] d;
        wr_log.delete();
        bus_start();
        write_byte(8'hD0, a);
        write_byte(8'h05, a);
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        reset = 1'b1;
        tick(1);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstdata_sda_oe got %b exp 0", sda_oe); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rstdata_busy got %b exp 0", busy); end
        reset = 1'b0;
        bus_idle();
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(a == 1'b1 ? (8'hD0 >> i) & 8'h01 : 1'b0);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstack_drive got %b exp 1", sda_oe); end
        reset = 1'b1;
        tick(1);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstack_sda_oe got %b exp 0", sda_oe); end
        reset = 1'b0;
        bus_idle();
        bus_start();
        write_byte(8'hD1, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rstread_addr_ack got %b exp 1", a); end
        for (int i = 0; i < 12; i++) begin
            read_byte(i < 11, d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("FAIL rstread_mem%0d got %h exp 00", i, d); end
        end
        bus_stop();
        checks++; if (wr_log.size() != 0) begin errors++; $display("FAIL rstmid_writes got %0d exp 0", wr_log.size()); end
    endtask

    initial begin
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_bad_reg();
        test_wrap();
        test_partial_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
